// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath widths, ALU operation codes and the EX-stage
// register bundle, including the bubble (NOP) value loaded on flush or stall.
package cpu_defs_pkg;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int CW  = 5;
  localparam int SHW = 5;

  localparam logic [CW-1:0] alu_add = 5'd0;
  localparam logic [CW-1:0] alu_sub = 5'd1;
  localparam logic [CW-1:0] alu_and = 5'd2;
  localparam logic [CW-1:0] alu_or  = 5'd3;
  localparam logic [CW-1:0] alu_xor = 5'd4;
  localparam logic [CW-1:0] alu_nor = 5'd5;
  localparam logic [CW-1:0] alu_slt = 5'd6;
  localparam logic [CW-1:0] alu_sll = 5'd7;
  localparam logic [CW-1:0] alu_srl = 5'd8;
  localparam logic [CW-1:0] alu_sra = 5'd9;
  localparam logic [CW-1:0] alu_mul = 5'd10;

  typedef struct packed {
    logic            valid;
    logic [CW-1:0]   alu_code;
    logic [RW-1:0]   rs;
    logic [RW-1:0]   rt;
    logic [RW-1:0]   rd;
    logic [DW-1:0]   rs_data;
    logic [DW-1:0]   rt_data;
    logic [DW-1:0]   imm;
    logic [SHW-1:0]  shamt;
    logic            alu_src_a;
    logic            alu_src_b;
    logic            reg_write;
    logic            mem_read;
  } ex_regs_t;

  // A bubble carries nothing that could write state or be forwarded.
  function automatic ex_regs_t ex_bubble();
    ex_regs_t b;
    b = '0;
    b.alu_code = alu_add;
    return b;
  endfunction

endpackage

// File: rtl/ex_forward_unit.sv
// Operand select for one EX source register: EX/MEM result, else MEM/WB data,
// else the value read from the register file in ID. Register $0 is never forwarded.
module ex_forward_unit
  import cpu_defs_pkg::*;
(
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] reg_data,
  input  logic          mem_RegWrite,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_RegWrite,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] data
);

  always_comb begin
    data = reg_data;
    if (mem_RegWrite && (mem_rd != '0) && (mem_rd == src))
      data = mem_result;
    else if (wb_RegWrite && (wb_rd != '0) && (wb_rd == src))
      data = wb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU operand selection, load-use bubble insertion and flush.
// EX_FWD_EN defined: EX/MEM and MEM/WB forwarding; undefined: stall until RAW producers retire.
module id_ex_stage
  import cpu_defs_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [CW-1:0]   id_ALUCode,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic [RW-1:0]   id_rd,
  input  logic [DW-1:0]   id_rs_data,
  input  logic [DW-1:0]   id_rt_data,
  input  logic [DW-1:0]   id_imm,
  input  logic [SHW-1:0]  id_shamt,
  input  logic            id_ALUSrcA,
  input  logic            id_ALUSrcB,
  input  logic            id_RegWrite,
  input  logic            id_MemRead,
  input  logic            flush,
  input  logic            mem_RegWrite,
  input  logic [RW-1:0]   mem_rd,
  input  logic [DW-1:0]   mem_result,
  input  logic            wb_RegWrite,
  input  logic [RW-1:0]   wb_rd,
  input  logic [DW-1:0]   wb_data,
  output logic            stall_id,
  output logic            ex_valid,
  output logic [CW-1:0]   ALUCode,
  output logic [DW-1:0]   A,
  output logic [DW-1:0]   B,
  output logic [DW-1:0]   ex_rt_fwd,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_RegWrite,
  output logic            ex_MemRead
);

  ex_regs_t      ex_q;
  ex_regs_t      ex_d;
  logic          load_use;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  always_comb begin
    load_use = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
               ((ex_q.rd == id_rs) || ((ex_q.rd == id_rt) && !id_ALUSrcB));
  end

`ifdef EX_FWD_EN
  assign stall_id = load_use;

  ex_forward_unit u_fwd_rs (
    .src(ex_q.rs), .reg_data(ex_q.rs_data),
    .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(fwd_rs)
  );

  ex_forward_unit u_fwd_rt (
    .src(ex_q.rt), .reg_data(ex_q.rt_data),
    .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(fwd_rt)
  );
`else
  logic rs_used;
  logic rt_used;
  logic raw_ex;
  logic raw_mem;
  logic unused_nofwd;

  // Without bypass paths, wait until the producer reaches WB; the regfile covers WB itself.
  always_comb begin
    rs_used  = !id_ALUSrcA;
    rt_used  = !id_ALUSrcB;
    raw_ex   = ex_q.reg_write && (ex_q.rd != '0) &&
               ((rs_used && (ex_q.rd == id_rs)) || (rt_used && (ex_q.rd == id_rt)));
    raw_mem  = mem_RegWrite && (mem_rd != '0) &&
               ((rs_used && (mem_rd == id_rs)) || (rt_used && (mem_rd == id_rt)));
    stall_id = load_use || (id_valid && (raw_ex || raw_mem));
  end

  assign fwd_rs       = ex_q.rs_data;
  assign fwd_rt       = ex_q.rt_data;
  assign unused_nofwd = ^{mem_result, wb_RegWrite, wb_rd, wb_data, ex_q.rs, ex_q.rt};
`endif

  always_comb begin
    ex_d = ex_bubble();
    if (!(flush || stall_id)) begin
      ex_d.valid     = id_valid;
      ex_d.alu_code  = id_ALUCode;
      ex_d.rs        = id_rs;
      ex_d.rt        = id_rt;
      ex_d.rd        = id_rd;
      ex_d.rs_data   = id_rs_data;
      ex_d.rt_data   = id_rt_data;
      ex_d.imm       = id_imm;
      ex_d.shamt     = id_shamt;
      ex_d.alu_src_a = id_ALUSrcA;
      ex_d.alu_src_b = id_ALUSrcB;
      ex_d.reg_write = id_RegWrite && id_valid;
      ex_d.mem_read  = id_MemRead && id_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ex_q <= '0;
    else
      ex_q <= ex_d;
  end

  assign A           = ex_q.alu_src_a ? {{(DW-SHW){1'b0}}, ex_q.shamt} : fwd_rs;
  assign B           = ex_q.alu_src_b ? ex_q.imm : fwd_rt;
  assign ex_rt_fwd   = fwd_rt;
  assign ex_valid    = ex_q.valid;
  assign ALUCode     = ex_q.alu_code;
  assign ex_rd       = ex_q.rd;
  assign ex_RegWrite = ex_q.reg_write;
  assign ex_MemRead  = ex_q.mem_read;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX outputs are queued at issue and a
// negedge monitor pops and compares whenever ex_valid is high.
`timescale 1ns/1ps
module tb_id_ex_stage;
  import cpu_defs_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid;
  logic [CW-1:0]   id_ALUCode;
  logic [RW-1:0]   id_rs, id_rt, id_rd;
  logic [DW-1:0]   id_rs_data, id_rt_data, id_imm;
  logic [SHW-1:0]  id_shamt;
  logic            id_ALUSrcA, id_ALUSrcB, id_RegWrite, id_MemRead;
  logic            flush;
  logic            mem_RegWrite, wb_RegWrite;
  logic [RW-1:0]   mem_rd, wb_rd;
  logic [DW-1:0]   mem_result, wb_data;
  logic            stall_id, ex_valid, ex_RegWrite, ex_MemRead;
  logic [CW-1:0]   ALUCode;
  logic [DW-1:0]   A, B, ex_rt_fwd;
  logic [RW-1:0]   ex_rd;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ALUCode(id_ALUCode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_ALUSrcA(id_ALUSrcA), .id_ALUSrcB(id_ALUSrcB),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .flush(flush),
    .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_id(stall_id), .ex_valid(ex_valid), .ALUCode(ALUCode), .A(A), .B(B),
    .ex_rt_fwd(ex_rt_fwd), .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [CW-1:0] code;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] rtf;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
  } exp_t;

  exp_t scoreboard[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && ex_valid) begin
      if (scoreboard.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_issue: ex_valid=1 ALUCode=%0d A=0x%0h with nothing expected",
                 ALUCode, A);
      end else begin
        mon_e = scoreboard.pop_front();
        chk($sformatf("%s.ALUCode", mon_e.name), ALUCode, mon_e.code);
        chk($sformatf("%s.A", mon_e.name), A, mon_e.a);
        chk($sformatf("%s.B", mon_e.name), B, mon_e.b);
        chk($sformatf("%s.rt_fwd", mon_e.name), ex_rt_fwd, mon_e.rtf);
        chk($sformatf("%s.rd", mon_e.name), ex_rd, mon_e.rd);
        chk($sformatf("%s.RegWrite", mon_e.name), ex_RegWrite, mon_e.rw);
        chk($sformatf("%s.MemRead", mon_e.name), ex_MemRead, mon_e.mr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_none();
    id_valid = 0; id_ALUCode = '0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_shamt = '0;
    id_ALUSrcA = 0; id_ALUSrcB = 0; id_RegWrite = 0; id_MemRead = 0;
  endtask

  task automatic id_set(input logic [CW-1:0] code, input logic [RW-1:0] rs, rt, rd,
                        input logic [DW-1:0] rsd, rtd, imm, input logic [SHW-1:0] sh,
                        input logic sa, sbb, rw, mr);
    id_valid = 1; id_ALUCode = code; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh;
    id_ALUSrcA = sa; id_ALUSrcB = sbb; id_RegWrite = rw; id_MemRead = mr;
  endtask

  task automatic fwd_set(input logic mrw, input logic [RW-1:0] mrd, input logic [DW-1:0] mres,
                         input logic wrw, input logic [RW-1:0] wrd, input logic [DW-1:0] wdat);
    mem_RegWrite = mrw; mem_rd = mrd; mem_result = mres;
    wb_RegWrite = wrw; wb_rd = wrd; wb_data = wdat;
  endtask

  task automatic expect_ex(input string name, input logic [CW-1:0] code,
                           input logic [DW-1:0] a, b, rtf, input logic [RW-1:0] rd,
                           input logic rw, mr);
    exp_t e;
    e.name = name; e.code = code; e.a = a; e.b = b; e.rtf = rtf;
    e.rd = rd; e.rw = rw; e.mr = mr;
    scoreboard.push_back(e);
  endtask

  task automatic chk_stall(input string name, input logic exp);
    #1;
    chk(name, stall_id, exp);
  endtask

  task automatic chk_bubble(input string name);
    chk({name, ".ex_valid"}, ex_valid, 0);
    chk({name, ".ALUCode"}, ALUCode, alu_add);
    chk({name, ".RegWrite"}, ex_RegWrite, 0);
    chk({name, ".MemRead"}, ex_MemRead, 0);
    chk({name, ".rd"}, ex_rd, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; flush = 0;
    id_none();
    fwd_set(0, 0, 0, 0, 0, 0);
    #12;
    chk("reset.ex_valid", ex_valid, 0);
    chk("reset.ALUCode", ALUCode, alu_add);
    chk("reset.A", A, 0);
    chk("reset.B", B, 0);
    chk("reset.stall", stall_id, 0);
    @(negedge clk);
    reset = 0;
    tick();

    // add $3,$1,$2 with $1=5, $2=7
    id_set(alu_add, 1, 2, 3, 5, 7, 0, 0, 0, 0, 1, 0);
    chk_stall("add.stall", 0);
    tick();
    expect_ex("add", alu_add, 5, 7, 7, 3, 1, 0);

`ifdef EX_FWD_EN
    // sub $4,$3,$1 picks up add's result from EX/MEM
    id_set(alu_sub, 3, 1, 4, 'hDEAD, 5, 0, 0, 0, 0, 1, 0);
    chk_stall("sub.stall", 0);
    tick();
    fwd_set(1, 3, 12, 0, 0, 0);
    expect_ex("sub_exmem", alu_sub, 12, 5, 5, 4, 1, 0);

    // lw $5,8($1)
    id_set(alu_add, 1, 5, 5, 5, 'h55, 8, 0, 0, 1, 1, 1);
    chk_stall("lw.stall", 0);
    tick();
    fwd_set(1, 4, 7, 1, 3, 12);
    expect_ex("lw", alu_add, 5, 8, 'h55, 5, 1, 1);

    // add $6,$5,$1 right behind the load
    id_set(alu_add, 5, 1, 6, 'hBAD, 5, 0, 0, 0, 0, 1, 0);
    chk_stall("load_use.stall", 1);
    tick();
    fwd_set(1, 5, 'h999, 1, 4, 7);
    chk_stall("load_use.released", 0);
    chk_bubble("load_use.bubble");
    tick();
    fwd_set(0, 0, 0, 1, 5, 'h1234);
    expect_ex("load_use_wb", alu_add, 'h1234, 5, 5, 6, 1, 0);

    // or $9,$7,$0: both stages write $7, EX/MEM wins
    id_set(alu_or, 7, 0, 9, 'h70, 0, 0, 0, 0, 0, 1, 0);
    chk_stall("or.stall", 0);
    tick();
    fwd_set(1, 7, 'hA, 1, 7, 'hB);
    expect_ex("prio_mem_over_wb", alu_or, 'hA, 0, 0, 9, 1, 0);

    // xor $11,$0,$2 while producers claim to write $0
    id_set(alu_xor, 0, 2, 11, 0, 'h22, 0, 0, 0, 0, 1, 0);
    tick();
    fwd_set(1, 0, 'h77, 1, 0, 'h88);
    expect_ex("rd0_no_fwd", alu_xor, 0, 'h22, 'h22, 11, 1, 0);

    // sll $12,$13,4 with $13 coming from EX/MEM
    id_set(alu_sll, 0, 13, 12, 0, 'h100, 0, 4, 1, 0, 1, 0);
    tick();
    fwd_set(1, 13, 'h40, 1, 13, 'h50);
    expect_ex("sll", alu_sll, 4, 'h40, 'h40, 12, 1, 0);

    // and $14,$1,$15 with $15 only in MEM/WB
    id_set(alu_and, 1, 15, 14, 5, 1, 0, 0, 0, 0, 1, 0);
    tick();
    fwd_set(1, 16, 'h5A, 1, 15, 'h3C);
    expect_ex("rt_from_wb", alu_and, 5, 'h3C, 'h3C, 14, 1, 0);
`else
    // add $4,$1,$3: RAW on rt must wait for add to leave EX and MEM
    id_set(alu_add, 1, 3, 4, 5, 'hDEAD, 0, 0, 0, 0, 1, 0);
    chk_stall("raw_ex.stall", 1);
    tick();
    fwd_set(1, 3, 12, 0, 0, 0);
    chk_stall("raw_mem.stall", 1);
    chk_bubble("raw.bubble1");
    tick();
    fwd_set(0, 0, 0, 1, 3, 12);
    id_rt_data = 12;
    chk_stall("raw.clear", 0);
    chk_bubble("raw.bubble2");
    tick();
    fwd_set(1, 3, 'h999, 1, 3, 'h888);
    expect_ex("raw_result", alu_add, 5, 12, 12, 4, 1, 0);

    // or $11,$9,$10 is independent of $3 in MEM
    id_set(alu_or, 9, 10, 11, 'hF0, 'h0F, 0, 0, 0, 0, 1, 0);
    chk_stall("or.stall", 0);
    tick();
    fwd_set(0, 0, 0, 0, 0, 0);
    expect_ex("or", alu_or, 'hF0, 'h0F, 'h0F, 11, 1, 0);

    // sll $12,$13,4
    id_set(alu_sll, 0, 13, 12, 0, 'h100, 0, 4, 1, 0, 1, 0);
    chk_stall("sll.stall", 0);
    tick();
    expect_ex("sll", alu_sll, 4, 'h100, 'h100, 12, 1, 0);

    // srl $14,$1,2: rs field equals $12 but a shift does not read rs
    id_set(alu_srl, 12, 1, 14, 'hBAD, 'h40, 0, 2, 1, 0, 1, 0);
    chk_stall("shift_rs_unused.stall", 0);
    tick();
    expect_ex("srl", alu_srl, 2, 'h40, 'h40, 14, 1, 0);
`endif

    // lw $8,0($1)
    id_set(alu_add, 1, 8, 8, 5, 'h66, 0, 0, 0, 1, 1, 1);
    chk_stall("lw8.stall", 0);
    tick();
    fwd_set(0, 0, 0, 0, 0, 0);
    expect_ex("lw8", alu_add, 5, 0, 'h66, 8, 1, 1);

    // load-use and flush together: bubble loaded, stall still reported
    id_set(alu_add, 8, 8, 9, 1, 1, 0, 0, 0, 0, 1, 0);
    flush = 1;
    chk_stall("flush_stall.stall", 1);
    tick();
    flush = 0;
    chk_bubble("flush_stall.bubble");

    // lw $8 again, then addi $10,$1,16 whose rt field is $8
    id_set(alu_add, 1, 8, 8, 5, 'h66, 0, 0, 0, 1, 1, 1);
    chk_stall("lw8b.stall", 0);
    tick();
    expect_ex("lw8b", alu_add, 5, 0, 'h66, 8, 1, 1);
    id_set(alu_add, 1, 8, 10, 5, 'h66, 'h10, 0, 0, 1, 1, 0);
    chk_stall("imm_rt.stall", 0);
    tick();
    expect_ex("addi", alu_add, 5, 'h10, 'h66, 10, 1, 0);

    // lw $0,4($1) followed by a reader of $0
    id_set(alu_add, 1, 0, 0, 5, 0, 4, 0, 0, 1, 1, 1);
    chk_stall("lw0.stall", 0);
    tick();
    expect_ex("lw0", alu_add, 5, 4, 0, 0, 1, 1);
    id_set(alu_add, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0);
    chk_stall("lw0_use.stall", 0);
    tick();
    expect_ex("add_r0", alu_add, 0, 0, 0, 2, 1, 0);

    // plain flush of a sub
    id_set(alu_sub, 1, 2, 20, 9, 3, 0, 0, 0, 0, 1, 0);
    flush = 1;
    tick();
    flush = 0;
    chk_bubble("flush.bubble");

    // reset while an instruction sits in EX
    id_set(alu_nor, 1, 2, 21, 'h3, 'h4, 0, 0, 0, 0, 1, 0);
    tick();
    expect_ex("pre_reset", alu_nor, 'h3, 'h4, 'h4, 21, 1, 0);
    @(negedge clk);
    #1 reset = 1;
    #1;
    chk("midreset.ex_valid", ex_valid, 0);
    chk("midreset.ALUCode", ALUCode, alu_add);
    chk("midreset.RegWrite", ex_RegWrite, 0);
    chk("midreset.A", A, 0);
    chk("midreset.B", B, 0);
    id_none();
    @(negedge clk);
    reset = 0;
    tick();
    chk("post_reset.ex_valid", ex_valid, 0);
    tick();

    chk("scoreboard.empty", scoreboard.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
